// File: rtl/core_mdu_ctrl.sv
// Two-port round-robin front-end for the shared multiply/divide unit: latches the op, runs the MDU, returns the result, flushes.
// Optional one-entry result cache enabled by defining CORE_MDU_RESULT_CACHE_EN.
module core_mdu_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [7:0]      req_op0,
    input  logic [7:0]      req_op1,
    input  logic [1:0]      req_word,
    input  logic [XLEN-1:0] req_rs1_0,
    input  logic [XLEN-1:0] req_rs2_0,
    input  logic [XLEN-1:0] req_rs1_1,
    input  logic [XLEN-1:0] req_rs2_1,
    input  logic [1:0]      cancel,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            mdu_valid,
    output logic            mdu_op_word,
    output logic            mdu_op_mul,
    output logic            mdu_op_mulh,
    output logic            mdu_op_mulhu,
    output logic            mdu_op_mulhsu,
    output logic            mdu_op_div,
    output logic            mdu_op_divu,
    output logic            mdu_op_rem,
    output logic            mdu_op_remu,
    output logic [XLEN-1:0] mdu_rs1,
    output logic [XLEN-1:0] mdu_rs2,
    output logic            mdu_flush,
    input  logic            mdu_ready,
    input  logic [XLEN-1:0] mdu_rd
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RSP, S_CLEAR} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [7:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              skip_clear_q, skip_clear_d;

    logic [1:0]        elig;
    logic [1:0]        grant;
    logic              sel;
    logic [7:0]        sel_op;
    logic [7:0]        sel_op_m1;
    logic              sel_op_ok;
    logic              sel_word;
    logic [XLEN-1:0]   sel_rs1;
    logic [XLEN-1:0]   sel_rs2;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_rd;

    // When both ports are eligible the one not served last wins.
    always_comb begin
        elig = req_valid & ~cancel;
        if (elig == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
        sel       = grant[1];
        sel_op    = sel ? req_op1 : req_op0;
        sel_word  = req_word[sel];
        sel_rs1   = sel ? req_rs1_1 : req_rs1_0;
        sel_rs2   = sel ? req_rs2_1 : req_rs2_0;
        sel_op_m1 = sel_op - 8'd1;
        sel_op_ok = (sel_op != 8'd0) && ((sel_op & sel_op_m1) == 8'd0);
    end

`ifdef CORE_MDU_RESULT_CACHE_EN
    logic              cache_vld_q, cache_vld_d;
    logic [7:0]        cache_op_q, cache_op_d;
    logic              cache_word_q, cache_word_d;
    logic [XLEN-1:0]   cache_rs1_q, cache_rs1_d;
    logic [XLEN-1:0]   cache_rs2_q, cache_rs2_d;
    logic [XLEN-1:0]   cache_res_q, cache_res_d;

    always_comb begin
        cache_vld_d  = cache_vld_q;
        cache_op_d   = cache_op_q;
        cache_word_d = cache_word_q;
        cache_rs1_d  = cache_rs1_q;
        cache_rs2_d  = cache_rs2_q;
        cache_res_d  = cache_res_q;
        if (state_q == S_RUN && mdu_ready && !cancel[owner_q]) begin
            cache_vld_d  = 1'b1;
            cache_op_d   = op_q;
            cache_word_d = word_q;
            cache_rs1_d  = rs1_q;
            cache_rs2_d  = rs2_q;
            cache_res_d  = mdu_rd;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            cache_vld_q  <= 1'b0;
            cache_op_q   <= 8'd0;
            cache_word_q <= 1'b0;
            cache_rs1_q  <= '0;
            cache_rs2_q  <= '0;
            cache_res_q  <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_op_q   <= cache_op_d;
            cache_word_q <= cache_word_d;
            cache_rs1_q  <= cache_rs1_d;
            cache_rs2_q  <= cache_rs2_d;
            cache_res_q  <= cache_res_d;
        end
    end

    assign cache_hit = cache_vld_q && (cache_op_q == sel_op) && (cache_word_q == sel_word)
                       && (cache_rs1_q == sel_rs1) && (cache_rs2_q == sel_rs2);
    assign cache_rd  = cache_res_q;
`else
    assign cache_hit = 1'b0;
    assign cache_rd  = '0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_d         = op_q;
        word_d       = word_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        result_d     = result_q;
        skip_clear_d = skip_clear_q;
        case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    owner_d      = sel;
                    last_grant_d = sel;
                    op_d         = sel_op;
                    word_d       = sel_word;
                    rs1_d        = sel_rs1;
                    rs2_d        = sel_rs2;
                    skip_clear_d = 1'b0;
                    if (!sel_op_ok) begin
                        result_d = '0;
                        state_d  = S_RSP;
                    end else if (cache_hit) begin
                        result_d     = cache_rd;
                        skip_clear_d = 1'b1;
                        state_d      = S_RSP;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            // Cancel beats a simultaneous mdu_ready: the result is dropped.
            S_RUN: begin
                if (cancel[owner_q]) begin
                    state_d = S_CLEAR;
                end else if (mdu_ready) begin
                    result_d = mdu_rd;
                    state_d  = S_RSP;
                end
            end
            S_RSP: begin
                if (cancel[owner_q]) begin
                    state_d = S_CLEAR;
                end else if (rsp_ready[owner_q]) begin
                    state_d = skip_clear_q ? S_IDLE : S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= 8'd0;
            word_q       <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            result_q     <= '0;
            skip_clear_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            word_q       <= word_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            result_q     <= result_d;
            skip_clear_q <= skip_clear_d;
        end
    end

    // Grant is combinational, so it must be masked while reset is held.
    assign req_ready = (state_q == S_IDLE && g_resetn) ? grant : 2'b00;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        assign rsp_valid[gi] = (state_q == S_RSP) && (owner_q == gi) && !cancel[gi];
    end

    assign rsp_data    = result_q;
    assign mdu_valid   = (state_q == S_RUN);
    assign mdu_flush   = (state_q == S_CLEAR);
    assign mdu_op_word = mdu_valid & word_q;
    assign {mdu_op_remu, mdu_op_rem, mdu_op_divu, mdu_op_div,
            mdu_op_mulhsu, mdu_op_mulhu, mdu_op_mulh, mdu_op_mul} = mdu_valid ? op_q : 8'd0;
    assign mdu_rs1     = rs1_q;
    assign mdu_rs2     = rs2_q;

endmodule

// File: tb/tb_core_mdu_ctrl.sv
// Scoreboard bench for core_mdu_ctrl with a behavioural fixed-latency MDU model.
// Define CORE_MDU_RESULT_CACHE_EN to also check the result-cache fast path.
module tb_core_mdu_ctrl;
    localparam int XLEN = 64;
    localparam int LAT  = 3;
    localparam int TMO  = 60;

    localparam logic [7:0] OP_MUL   = 8'b0000_0001;
    localparam logic [7:0] OP_MULHU = 8'b0000_0100;
    localparam logic [7:0] OP_DIV   = 8'b0001_0000;
    localparam logic [7:0] OP_DIVU  = 8'b0010_0000;
    localparam logic [7:0] OP_REMU  = 8'b1000_0000;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [7:0]      req_op0 = 8'd0, req_op1 = 8'd0;
    logic [1:0]      req_word = 2'b00;
    logic [XLEN-1:0] req_rs1_0 = '0, req_rs2_0 = '0, req_rs1_1 = '0, req_rs2_1 = '0;
    logic [1:0]      cancel = 2'b00;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready = 2'b11;
    logic [XLEN-1:0] rsp_data;
    logic            mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu;
    logic            mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu;
    logic [XLEN-1:0] mdu_rs1, mdu_rs2;
    logic            mdu_flush;
    logic            mdu_ready;
    logic [XLEN-1:0] mdu_rd;

    core_mdu_ctrl #(.XLEN(XLEN)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_word(req_word),
        .req_rs1_0(req_rs1_0), .req_rs2_0(req_rs2_0), .req_rs1_1(req_rs1_1), .req_rs2_1(req_rs2_1),
        .cancel(cancel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mdu_valid(mdu_valid), .mdu_op_word(mdu_op_word), .mdu_op_mul(mdu_op_mul),
        .mdu_op_mulh(mdu_op_mulh), .mdu_op_mulhu(mdu_op_mulhu), .mdu_op_mulhsu(mdu_op_mulhsu),
        .mdu_op_div(mdu_op_div), .mdu_op_divu(mdu_op_divu), .mdu_op_rem(mdu_op_rem),
        .mdu_op_remu(mdu_op_remu), .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2),
        .mdu_flush(mdu_flush), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd)
    );

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic        port;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   mdu_valid_cnt = 0;
    int   flush_cnt = 0;
    int   mdu_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mdu(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        logic         ovf;
        sa  = {{64{a[63]}}, a};
        sb  = {{64{b[63]}}, b};
        ua  = {64'd0, a};
        ub  = {64'd0, b};
        ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
        p   = '0;
        ref_mdu = '0;
        if (op[0]) begin p = ua * ub; ref_mdu = p[63:0]; end
        else if (op[1]) begin p = sa * sb; ref_mdu = p[127:64]; end
        else if (op[2]) begin p = ua * ub; ref_mdu = p[127:64]; end
        else if (op[3]) begin p = sa * ub; ref_mdu = p[127:64]; end
        else if (op[4]) ref_mdu = (b == 0) ? '1 : ovf ? a : 64'($signed(a) / $signed(b));
        else if (op[5]) ref_mdu = (b == 0) ? '1 : a / b;
        else if (op[6]) ref_mdu = (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
        else if (op[7]) ref_mdu = (b == 0) ? a : a % b;
    endfunction

    // Fixed-latency MDU: ready LAT cycles after the first mdu_valid cycle.
    always @(posedge g_clk) begin
        cyc <= cyc + 1;
        if (!mdu_valid || mdu_flush) mdu_cnt <= 0;
        else mdu_cnt <= mdu_cnt + 1;
        if (mdu_valid) mdu_valid_cnt <= mdu_valid_cnt + 1;
        if (mdu_flush) flush_cnt <= flush_cnt + 1;
    end

    assign mdu_ready = mdu_valid && (mdu_cnt == LAT);
    always_comb begin
        mdu_rd = ref_mdu({mdu_op_remu, mdu_op_rem, mdu_op_divu, mdu_op_div,
                          mdu_op_mulhsu, mdu_op_mulhu, mdu_op_mulh, mdu_op_mul}, mdu_rs1, mdu_rs2);
    end

    always @(negedge g_clk) begin : monitor
        exp_t e;
        if (g_resetn) begin
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    $display("rsp port %0d data 0x%h cycle %0d", p, rsp_data, cyc);
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_port", 64'(p), 64'(e.port));
                        check("sb_data", rsp_data, e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accept edge with t_acc = handshake cycle.
    task automatic issue(input int p, input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] expd, input bit push, output int t_acc);
        bit got = 0;
        if (p == 0) begin req_op0 = op; req_rs1_0 = a; req_rs2_0 = b; end
        else begin req_op1 = op; req_rs1_1 = a; req_rs2_1 = b; end
        req_valid[p] = 1'b1;
        if (push) sb_q.push_back('{port: p[0], data: expd});
        t_acc = cyc;
        for (int i = 0; i < TMO; i++) begin
            #1;
            if (req_ready[p]) begin
                t_acc = cyc;
                @(posedge g_clk);
                #1;
                req_valid[p] = 1'b0;
                got = 1;
                break;
            end
            @(negedge g_clk);
        end
        if (!got) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_valid[p] = 1'b0;
        end
        @(negedge g_clk);
    endtask

    task automatic wait_rsp(input int p, output int t);
        bit got = 0;
        t = cyc;
        for (int i = 0; i < TMO; i++) begin
            if (rsp_valid[p]) begin t = cyc; got = 1; break; end
            @(negedge g_clk);
        end
        if (!got) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < TMO * 4; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge g_clk);
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge g_clk);
    endtask

    // Both ports request together; 'first' is the port expected to be granted first.
    task automatic issue_pair(input int first, input logic [63:0] e0, input logic [63:0] e1);
        int  second = 1 - first;
        bit  got = 0;
        req_op0 = OP_DIVU; req_rs1_0 = 64'd100; req_rs2_0 = 64'd7;
        req_op1 = OP_REMU; req_rs1_1 = 64'd100; req_rs2_1 = 64'd7;
        sb_q.push_back('{port: first[0], data: (first == 0) ? e0 : e1});
        sb_q.push_back('{port: second[0], data: (second == 0) ? e0 : e1});
        req_valid = 2'b11;
        #1;
        check("pair_grant", 64'(req_ready), (first == 0) ? 64'd1 : 64'd2);
        @(posedge g_clk);
        #1;
        req_valid[first] = 1'b0;
        @(negedge g_clk);
        for (int i = 0; i < TMO; i++) begin
            #1;
            if (req_ready[second]) begin
                @(posedge g_clk);
                #1;
                got = 1;
                break;
            end
            @(negedge g_clk);
        end
        req_valid[second] = 1'b0;
        if (!got) check("pair_second_timeout", 64'd0, 64'd1);
        @(negedge g_clk);
        drain();
    endtask

    initial begin : main
        int t, tr, v0, f0;
        repeat (3) @(negedge g_clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_mdu_valid", 64'(mdu_valid), 64'd0);
        check("rst_mdu_flush", 64'(mdu_flush), 64'd0);
        g_resetn = 1'b1;
        @(negedge g_clk);

        // Fresh reset: port 0 wins the tie.
        issue_pair(0, 64'd14, 64'd2);

        // Single MUL with latency and flush timing.
        issue(0, OP_MUL, 64'd3, 64'd5, 64'd15, 1, t);
        check("t1_mdu_valid", 64'(mdu_valid), 64'd1);
        check("t1_mdu_rs1", mdu_rs1, 64'd3);
        check("t1_mdu_op_mul", 64'(mdu_op_mul), 64'd1);
        wait_rsp(0, tr);
        check("t1_rsp_latency", 64'(tr - t), 64'(LAT + 2));
        f0 = flush_cnt;
        @(negedge g_clk);
        check("t1_flush_after_hs", 64'(mdu_flush), 64'd1);
        check("t1_rsp_dropped", 64'(rsp_valid), 64'd0);
        @(negedge g_clk);
        check("t1_flush_once", 64'(flush_cnt - f0), 64'd1);
        check("t1_flush_low", 64'(mdu_flush), 64'd0);
        drain();

        // Port 0 was granted last, so port 1 wins the repeated tie.
        issue_pair(1, 64'd14, 64'd2);

        // Invalid (not one-hot) op: immediate zero result, MDU untouched.
        v0 = mdu_valid_cnt;
        issue(0, 8'b0000_0011, 64'd9, 64'd9, 64'd0, 1, t);
        wait_rsp(0, tr);
        check("inv_rsp_latency", 64'(tr - t), 64'd1);
        drain();
        check("inv_no_mdu_valid", 64'(mdu_valid_cnt - v0), 64'd0);

        // Divide by zero, then an ordinary op.
        issue(1, OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, t);
        drain();
        issue(0, OP_MUL, 64'd7, 64'd6, 64'd42, 1, t);
        drain();

        // Cancel coinciding with mdu_ready: no response, flush next cycle.
        issue(0, OP_MUL, 64'd11, 64'd13, 64'd0, 0, t);
        for (int i = 0; i < TMO; i++) begin
            if (mdu_ready) break;
            @(negedge g_clk);
        end
        check("cxl_mdu_ready_seen", 64'(mdu_ready), 64'd1);
        cancel[0] = 1'b1;
        @(posedge g_clk);
        #1;
        cancel[0] = 1'b0;
        @(negedge g_clk);
        check("cxl_flush", 64'(mdu_flush), 64'd1);
        check("cxl_no_rsp", 64'(rsp_valid), 64'd0);
        check("cxl_mdu_valid", 64'(mdu_valid), 64'd0);
        @(negedge g_clk);
        check("cxl_flush_done", 64'(mdu_flush), 64'd0);
        check("cxl_still_no_rsp", 64'(rsp_valid), 64'd0);

        // Reset while RUN.
        issue(0, OP_MUL, 64'd5, 64'd5, 64'd0, 0, t);
        check("mrst_in_run", 64'(mdu_valid), 64'd1);
        g_resetn = 1'b0;
        req_valid = 2'b11;
        @(negedge g_clk);
        check("mrst_req_ready", 64'(req_ready), 64'd0);
        check("mrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mrst_rsp_data", rsp_data, 64'd0);
        check("mrst_mdu_valid", 64'(mdu_valid), 64'd0);
        check("mrst_mdu_flush", 64'(mdu_flush), 64'd0);
        check("mrst_mdu_rs", {mdu_rs1[31:0], mdu_rs2[31:0]}, 64'd0);
        check("mrst_mdu_ops", 64'({mdu_op_word, mdu_op_remu, mdu_op_rem, mdu_op_divu, mdu_op_div,
                                   mdu_op_mulhsu, mdu_op_mulhu, mdu_op_mulh, mdu_op_mul}), 64'd0);
        req_valid = 2'b00;
        g_resetn = 1'b1;
        @(negedge g_clk);
        issue(1, OP_MUL, 64'h10, 64'h10, 64'h100, 1, t);
        drain();

        // Repeated MULHU: second one may come from the result cache.
        issue(0, OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1, t);
        wait_rsp(0, tr);
        check("c1_rsp_latency", 64'(tr - t), 64'(LAT + 2));
        drain();
        v0 = mdu_valid_cnt;
        f0 = flush_cnt;
        issue(0, OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1, t);
        wait_rsp(0, tr);
`ifdef CORE_MDU_RESULT_CACHE_EN
        check("c2_rsp_latency", 64'(tr - t), 64'd1);
        drain();
        check("c2_no_mdu_valid", 64'(mdu_valid_cnt - v0), 64'd0);
        check("c2_no_flush", 64'(flush_cnt - f0), 64'd0);
`else
        check("c2_rsp_latency", 64'(tr - t), 64'(LAT + 2));
        drain();
        check("c2_mdu_valid", 64'(mdu_valid_cnt - v0), 64'(LAT + 1));
        check("c2_flush", 64'(flush_cnt - f0), 64'd1);
`endif

        repeat (3) @(negedge g_clk);
        check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
